dense_acc_latch: RTL and testbench

DENSE_ACC_LATCH -- requirements
Module: dense_acc_latch

---
 rtl/dense_acc_latch_if.sv | 15 +
 rtl/dense_acc_latch.sv | 136 +++++++++++++
 tb/tb_dense_acc_latch.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_acc_latch_if.sv
// Read channel of dense_acc_latch: request (en/addr) from the reader, registered response back.
interface dense_acc_latch_if #(
    parameter int unsigned N_PE   = 8,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned AW = (N_PE > 1) ? $clog2(N_PE) : 1;

    logic              dense_rd_en;
    logic [AW-1:0]     dense_rd_addr;
    logic [DATA_W-1:0] dense_rd_data;
    logic              dense_rd_valid;

    modport master (output dense_rd_en, dense_rd_addr, input dense_rd_data, dense_rd_valid);
    modport slave  (input dense_rd_en, dense_rd_addr, output dense_rd_data, dense_rd_valid);
endinterface

// File: rtl/dense_acc_latch.sv
// Per-lane dense accumulators with narrowing, nonlinearity capture, latch bank and 1-cycle read port.
// Optional macro DENSE_ACC_SAT_EN: saturating accumulate plus sticky acc_overflow flag.
module dense_acc_latch #(
    parameter int unsigned N_PE   = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dense_enable,
    input  logic [N_PE*ACC_W-1:0] mac_sum,
    input  logic [N_PE-1:0]       dense_adder_on,
    input  logic [N_PE-1:0]       dense_adder_reset,
    input  logic [N_PE-1:0]       nl_enable,
    input  logic [1:0]            nl_type,
    input  logic                  dense_latch,
    dense_acc_latch_if.slave      rd,
    output logic                  acc_overflow
);
    localparam int unsigned AW    = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic signed [ACC_W-1:0]  NAR_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  NAR_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  r_acc   [N_PE];
    logic signed [DATA_W-1:0] r_nl    [N_PE];
    logic signed [DATA_W-1:0] r_latch [N_PE];
    logic [DATA_W-1:0]        r_rd_data;
    logic                     r_rd_valid;

    logic signed [ACC_W-1:0]  w_mac     [N_PE];
    logic signed [ACC_W-1:0]  w_add     [N_PE];
    logic signed [ACC_W-1:0]  w_shift   [N_PE];
    logic signed [DATA_W-1:0] w_nar     [N_PE];
    logic signed [DATA_W-1:0] w_nl      [N_PE];
    logic signed [ACC_W-1:0]  w_acc_nxt [N_PE];
    logic [DATA_W-1:0]        w_bank    [DEPTH];
    logic [DATA_W-1:0]        w_rd_word;

`ifdef DENSE_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] w_sum     [N_PE];
    logic           w_add_sat [N_PE];
    logic           w_nar_sat [N_PE];
    logic           w_ovf_set;
    logic           r_ovf;
`endif

    // Per-lane datapath: add, narrow, nonlinearity and next accumulator value
    always_comb begin
`ifdef DENSE_ACC_SAT_EN
        w_ovf_set = 1'b0;
`endif
        for (int i = 0; i < N_PE; i++) begin
            w_mac[i] = $signed(mac_sum[i*ACC_W +: ACC_W]);
`ifdef DENSE_ACC_SAT_EN
            w_sum[i]     = {r_acc[i][ACC_W-1], r_acc[i]} + {w_mac[i][ACC_W-1], w_mac[i]};
            w_add_sat[i] = w_sum[i][ACC_W] != w_sum[i][ACC_W-1];
            if (w_add_sat[i]) w_add[i] = w_sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
            else              w_add[i] = $signed(w_sum[i][ACC_W-1:0]);
`else
            w_add[i] = r_acc[i] + w_mac[i];
`endif
            w_shift[i] = r_acc[i] >>> FRAC_W;
            if (w_shift[i] > NAR_MAX)      w_nar[i] = OUT_MAX;
            else if (w_shift[i] < NAR_MIN) w_nar[i] = OUT_MIN;
            else                           w_nar[i] = $signed(w_shift[i][DATA_W-1:0]);
`ifdef DENSE_ACC_SAT_EN
            w_nar_sat[i] = (w_shift[i] > NAR_MAX) || (w_shift[i] < NAR_MIN);
`endif
            case (nl_type)
                2'd1:    w_nl[i] = w_nar[i][DATA_W-1] ? '0 : w_nar[i];
                2'd2:    w_nl[i] = w_nar[i][DATA_W-1] ? (w_nar[i] >>> 3) : w_nar[i];
                default: w_nl[i] = w_nar[i];
            endcase
            // Capture restarts the accumulator with this cycle's sum so no cycle is lost
            if (nl_enable[i])                               w_acc_nxt[i] = dense_adder_on[i] ? w_mac[i] : '0;
            else if (dense_adder_on[i])                     w_acc_nxt[i] = w_add[i];
            else if (dense_adder_reset[i] && !dense_enable) w_acc_nxt[i] = '0;
            else                                            w_acc_nxt[i] = r_acc[i];
`ifdef DENSE_ACC_SAT_EN
            if ((nl_enable[i] && w_nar_sat[i]) || (!nl_enable[i] && dense_adder_on[i] && w_add_sat[i]))
                w_ovf_set = 1'b1;
`endif
        end
    end

    // Read bank padded to a power of two; unpopulated addresses read as zero
    for (genvar j = 0; j < DEPTH; j++) begin : g_bank
        if (j < N_PE) begin : g_live
            assign w_bank[j] = r_latch[j];
        end else begin : g_pad
            assign w_bank[j] = '0;
        end
    end
    assign w_rd_word = w_bank[rd.dense_rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PE; i++) begin
                r_acc[i]   <= '0;
                r_nl[i]    <= '0;
                r_latch[i] <= '0;
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
`ifdef DENSE_ACC_SAT_EN
            r_ovf      <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < N_PE; i++) begin
                r_acc[i] <= w_acc_nxt[i];
                if (nl_enable[i]) r_nl[i]    <= w_nl[i];
                if (dense_latch)  r_latch[i] <= r_nl[i];
            end
            r_rd_valid <= rd.dense_rd_en;
            if (rd.dense_rd_en) r_rd_data <= w_rd_word;
`ifdef DENSE_ACC_SAT_EN
            if (w_ovf_set) r_ovf <= 1'b1;
`endif
        end
    end

    assign rd.dense_rd_data  = r_rd_data;
    assign rd.dense_rd_valid = r_rd_valid;
`ifdef DENSE_ACC_SAT_EN
    assign acc_overflow = r_ovf;
`else
    assign acc_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_dense_acc_latch.sv
// Directed bench for dense_acc_latch: reads push expected words, a negedge monitor pops and compares.
module tb_dense_acc_latch;
    logic         clk = 1'b0;
    logic         rst;
    logic         dense_enable;
    logic [255:0] mac_sum;
    logic [7:0]   dense_adder_on;
    logic [7:0]   dense_adder_reset;
    logic [7:0]   nl_enable;
    logic [1:0]   nl_type;
    logic         dense_latch;
    logic         acc_overflow;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = '0;

    dense_acc_latch_if #(.N_PE(8), .DATA_W(16)) rd_if ();

    dense_acc_latch #(.N_PE(8), .ACC_W(32), .DATA_W(16), .FRAC_W(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .dense_enable      (dense_enable),
        .mac_sum           (mac_sum),
        .dense_adder_on    (dense_adder_on),
        .dense_adder_reset (dense_adder_reset),
        .nl_enable         (nl_enable),
        .nl_type           (nl_type),
        .dense_latch       (dense_latch),
        .rd                (rd_if.slave),
        .acc_overflow      (acc_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rd_if.dense_rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %0h expected no response at %0t",
                         rd_if.dense_rd_data, $time);
            end else begin
                check("rd_data", 32'(rd_if.dense_rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accum(input int lane, input logic [31:0] v);
        mac_sum[lane*32 +: 32] = v;
        dense_adder_on = 8'(1) << lane;
        tick();
        dense_adder_on = '0;
    endtask

    task automatic capture(input logic [7:0] lanes, input logic [1:0] t);
        nl_type   = t;
        nl_enable = lanes;
        tick();
        nl_enable = '0;
    endtask

    task automatic do_latch();
        dense_latch = 1'b1;
        tick();
        dense_latch = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [15:0] exp);
        rd_if.dense_rd_en   = 1'b1;
        rd_if.dense_rd_addr = 3'(addr);
        exp_q.push_back(exp);
        last_exp = exp;
        tick();
    endtask

    task automatic rd_stop();
        rd_if.dense_rd_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; dense_enable = 1'b0; mac_sum = '0; dense_adder_on = '0;
        dense_adder_reset = '0; nl_enable = '0; nl_type = '0; dense_latch = 1'b0;
        rd_if.dense_rd_en = 1'b0; rd_if.dense_rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_valid", 32'(rd_if.dense_rd_valid), 32'd0);
        check("reset_data", 32'(rd_if.dense_rd_data), 32'd0);
        check("reset_ovf", 32'(acc_overflow), 32'd0);

        // Lane 0: 3 x 256 -> 3
        mac_sum[31:0] = 32'd256;
        dense_adder_on = 8'h01;
        tick(); tick(); tick();
        dense_adder_on = '0;
        capture(8'h01, 2'd0);
        do_latch();
        rd(0, 16'd3);
        rd_stop();
        check("hold_valid", 32'(rd_if.dense_rd_valid), 32'd0);
        check("hold_data", 32'(rd_if.dense_rd_data), 32'(last_exp));

        // Lane 2: -2048 through ReLU -> 0, through leaky -> -1
        accum(2, 32'hFFFF_F800);
        capture(8'h04, 2'd1);
        do_latch();
        rd(2, 16'd0);
        rd_stop();
        accum(2, 32'hFFFF_F800);
        capture(8'h04, 2'd2);
        do_latch();
        rd(2, 16'hFFFF);
        rd_stop();

        // Lane 1: capture while accumulating restarts acc at mac_sum
        mac_sum[63:32] = 32'd512;
        dense_adder_on = 8'h02;
        tick(); tick(); tick();
        mac_sum[63:32] = 32'd100;
        nl_enable = 8'h02;
        nl_type   = 2'd0;
        tick();
        nl_enable = '0;
        dense_adder_on = '0;
        do_latch();
        rd(1, 16'd6);
        rd_stop();
        accum(1, 32'd156);
        capture(8'h02, 2'd0);
        do_latch();
        rd(1, 16'd1);
        rd_stop();

        // All lanes k*256 -> k, then burst reads with a latch colliding on the last one
        for (int k = 0; k < 8; k++) mac_sum[k*32 +: 32] = 32'(k * 256);
        dense_adder_on = 8'hFF;
        tick();
        dense_adder_on = '0;
        capture(8'hFF, 2'd0);
        do_latch();
        for (int k = 0; k < 8; k++) mac_sum[k*32 +: 32] = 32'd4096;
        dense_adder_on = 8'hFF;
        tick();
        dense_adder_on = '0;
        capture(8'hFF, 2'd0);
        for (int k = 0; k < 7; k++) rd(k, 16'(k));
        dense_latch = 1'b1;
        rd(7, 16'd7);
        dense_latch = 1'b0;
        rd(7, 16'd16);
        rd(0, 16'd16);
        rd_stop();

        // Capture and latch in the same cycle: latch takes the old NL value
        accum(3, 32'd1280);
        nl_enable = 8'h08;
        dense_latch = 1'b1;
        tick();
        nl_enable = '0;
        dense_latch = 1'b0;
        rd(3, 16'd16);
        rd_stop();
        do_latch();
        rd(3, 16'd5);
        rd_stop();

        // Add overflow and narrowing saturation
        accum(4, 32'h7FFF_FF00);
        accum(4, 32'h0000_0200);
`ifdef DENSE_ACC_SAT_EN
        check("add_ovf_flag", 32'(acc_overflow), 32'd1);
`else
        check("add_ovf_flag", 32'(acc_overflow), 32'd0);
`endif
        capture(8'h10, 2'd0);
        accum(5, 32'h0100_0000);
        capture(8'h20, 2'd0);
        do_latch();
`ifdef DENSE_ACC_SAT_EN
        rd(4, 16'h7FFF);
`else
        rd(4, 16'h8000);
`endif
        rd(5, 16'h7FFF);
        rd_stop();

        // Clear request: ignored in dense mode, honoured otherwise
        accum(6, 32'd768);
        dense_enable = 1'b1;
        dense_adder_reset = 8'h40;
        tick();
        dense_adder_reset = '0;
        dense_enable = 1'b0;
        capture(8'h40, 2'd0);
        do_latch();
        rd(6, 16'd3);
        rd_stop();
        accum(6, 32'd768);
        dense_adder_reset = 8'h40;
        tick();
        dense_adder_reset = '0;
        capture(8'h40, 2'd0);
        do_latch();
        rd(6, 16'd0);
        rd_stop();

        // Reset during accumulation and read
        mac_sum[31:0] = 32'd256;
        dense_adder_on = 8'h01;
        tick();
        rd(0, 16'd16);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dense_adder_on = '0;
        rd_if.dense_rd_en = 1'b0;
        check("rst_valid", 32'(rd_if.dense_rd_valid), 32'd0);
        check("rst_data", 32'(rd_if.dense_rd_data), 32'd0);
        check("rst_ovf", 32'(acc_overflow), 32'd0);
        tick();
        capture(8'hFF, 2'd0);
        do_latch();
        for (int k = 0; k < 8; k++) rd(k, 16'd0);
        rd_stop();

        tick(); tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
